// File: rtl/mem_pkg.sv
// Shared definitions for the burst main memory: bus widths, acc_size
// encodings, the default base address and the burst-length decode.
package mem_pkg;

  localparam int ADDRESS_SIZE = 32;
  localparam int DATA_SIZE    = 32;
  localparam int MEM_WIDTH    = 8;
  localparam int ACCESS_SIZE  = 2;

  localparam logic [ADDRESS_SIZE-1:0] MEM_BASE_ADDR = 32'h8002_0000;

  typedef enum logic [ACCESS_SIZE-1:0] {
    ACC_1W  = 2'b00,
    ACC_4W  = 2'b01,
    ACC_8W  = 2'b10,
    ACC_16W = 2'b11
  } acc_size_t;

  function automatic logic [4:0] burst_len(input logic [ACCESS_SIZE-1:0] acc);
    logic [4:0] n;
    case (acc)
      ACC_1W:  n = 5'd1;
      ACC_4W:  n = 5'd4;
      ACC_8W:  n = 5'd8;
      default: n = 5'd16;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/main_mem_burst_if.sv
// Request/response bus between the fetch/LSU front-ends (master) and the
// burst main memory (slave).
interface main_mem_burst_if;
  import mem_pkg::*;

  logic                    en;
  logic                    wren;
  logic [ADDRESS_SIZE-1:0] addr;
  logic [ACCESS_SIZE-1:0]  acc_size;
  logic [DATA_SIZE-1:0]    d_in;
  logic [DATA_SIZE-1:0]    d_out;
  logic                    d_valid;
  logic                    busy;
  logic                    err;

  modport master (
    output en, wren, addr, acc_size, d_in,
    input  d_out, d_valid, busy, err
  );

  modport slave (
    input  en, wren, addr, acc_size, d_in,
    output d_out, d_valid, busy, err
  );
endinterface

// File: rtl/mem_byte_array.sv
// Byte storage with one aligned 4-byte big-endian word port: synchronous
// write, registered read whose output register holds until the next read.
module mem_byte_array
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = 1048576,
  parameter int WORD_AW   = $clog2(MEM_BYTES / 4)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 re,
  input  logic [WORD_AW-1:0]   word_addr,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic [DATA_SIZE-1:0] rdata
);
  localparam int LANES = DATA_SIZE / MEM_WIDTH;
  localparam int WORDS = MEM_BYTES / LANES;

  // Lane gi holds the byte at offset 4*w+gi; lane 0 is the most significant byte.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [MEM_WIDTH-1:0] lane_mem [WORDS];
    logic [MEM_WIDTH-1:0] rd_reg;

    always_ff @(posedge clk) begin
      if (we) begin
        lane_mem[word_addr] <= wdata[DATA_SIZE-1-gi*MEM_WIDTH -: MEM_WIDTH];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_reg <= '0;
      end else if (re) begin
        rd_reg <= lane_mem[word_addr];
      end
    end

    assign rdata[DATA_SIZE-1-gi*MEM_WIDTH -: MEM_WIDTH] = rd_reg;
  end
endmodule

// File: rtl/main_mem_burst.sv
// Big-endian main memory with 1/4/8/16-word bursts, busy/d_valid handshake,
// base-address window and one-cycle err pulse on rejected requests.
module main_mem_burst
  import mem_pkg::*;
#(
  parameter int                      MEM_BYTES = 1048576,
  parameter logic [ADDRESS_SIZE-1:0] BASE_ADDR = MEM_BASE_ADDR
) (
  input logic             clk,
  input logic             rst,
  main_mem_burst_if.slave bus
);
  localparam int WORD_AW = $clog2(MEM_BYTES / 4);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RD_BURST = 2'd1;
  localparam logic [1:0] ST_WR_BURST = 2'd2;

  logic [1:0]             state_reg, state_next;
  logic [4:0]             beat_reg, beat_next;
  logic [4:0]             last_reg, last_next;
  logic [WORD_AW-1:0]     addr_reg, addr_next;
  logic                   err_reg, err_next;
  logic                   d_valid_reg;

  logic [ADDRESS_SIZE-1:0] offset;
  logic [ADDRESS_SIZE:0]   end_byte;
  logic [4:0]              req_len;
  logic [WORD_AW-1:0]      req_word;
  logic                    bad_req;
  logic                    req;

  logic                    mem_we;
  logic                    mem_re;
  logic [WORD_AW-1:0]      mem_addr;
  logic [DATA_SIZE-1:0]    mem_rdata;

  // One extra bit on the end address keeps offsets near 4 GB from wrapping into range.
  assign req_len  = burst_len(bus.acc_size);
  assign offset   = bus.addr - BASE_ADDR;
  assign end_byte = {1'b0, offset} + {26'd0, req_len, 2'b00};
  assign req_word = offset[WORD_AW+1:2];
  assign bad_req  = (bus.addr[1:0] != 2'b00) || (bus.addr < BASE_ADDR) ||
                    (end_byte > (ADDRESS_SIZE+1)'(MEM_BYTES));
  assign req      = bus.en && !rst;

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    last_next  = last_reg;
    addr_next  = addr_reg;
    err_next   = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = addr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (bad_req) begin
            err_next = 1'b1;
          end else begin
            // Beat 0 is serviced in the accept cycle straight from the request address.
            mem_addr = req_word;
            mem_we   = bus.wren;
            mem_re   = !bus.wren;
            if (req_len != 5'd1) begin
              state_next = bus.wren ? ST_WR_BURST : ST_RD_BURST;
              beat_next  = 5'd1;
              last_next  = req_len - 5'd1;
              addr_next  = req_word + 1'b1;
            end
          end
        end
      end
      ST_RD_BURST, ST_WR_BURST: begin
        mem_we = (state_reg == ST_WR_BURST);
        mem_re = (state_reg == ST_RD_BURST);
        if (beat_reg == last_reg) begin
          state_next = ST_IDLE;
          beat_next  = 5'd0;
        end else begin
          beat_next = beat_reg + 5'd1;
          addr_next = addr_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        beat_next  = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      beat_reg    <= 5'd0;
      last_reg    <= 5'd0;
      addr_reg    <= '0;
      err_reg     <= 1'b0;
      d_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      beat_reg    <= beat_next;
      last_reg    <= last_next;
      addr_reg    <= addr_next;
      err_reg     <= err_next;
      d_valid_reg <= mem_re;
    end
  end

  mem_byte_array #(
    .MEM_BYTES (MEM_BYTES),
    .WORD_AW   (WORD_AW)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .we        (mem_we),
    .re        (mem_re),
    .word_addr (mem_addr),
    .wdata     (bus.d_in),
    .rdata     (mem_rdata)
  );

  assign bus.busy    = (state_reg != ST_IDLE);
  assign bus.err     = err_reg;
  assign bus.d_valid = d_valid_reg;
  assign bus.d_out   = mem_rdata;
endmodule

// File: tb/tb_main_mem_burst.sv
// Self-checking bench for main_mem_burst: randomized bursts checked against a
// byte-array reference model with explicit per-cycle handshake expectations.
module tb_main_mem_burst;
  localparam int          MEM_BYTES = 1048576;
  localparam logic [31:0] BASE      = 32'h8002_0000;

  typedef logic [31:0] words_t [16];

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit [7:0] ref_mem [MEM_BYTES];

  main_mem_burst_if bus();

  main_mem_burst #(.MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int len_of(input logic [1:0] acc);
    case (acc)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 16;
    endcase
  endfunction

  function automatic bit ref_bad(input logic [31:0] a, input logic [1:0] acc);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (a % 4 != 0) || (off < 0) || (off + 4 * len_of(acc) > MEM_BYTES);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int unsigned o;
    o = a - BASE;
    return {ref_mem[o], ref_mem[o+1], ref_mem[o+2], ref_mem[o+3]};
  endfunction

  task automatic ref_put(input logic [31:0] a, input logic [31:0] w);
    int unsigned o;
    o = a - BASE;
    ref_mem[o]   = w[31:24];
    ref_mem[o+1] = w[23:16];
    ref_mem[o+2] = w[15:8];
    ref_mem[o+3] = w[7:0];
  endtask

  function automatic logic [31:0] valid_mask(input int n);
    return ((32'd1 << n) - 32'd1) << 1;
  endfunction

  function automatic logic [31:0] busy_mask(input int n);
    return ((32'd1 << (n - 1)) - 32'd1) << 1;
  endfunction

  // Issues one request in cycle 0 and records busy/d_valid/err for cycles 1..N+2.
  task automatic drive_burst(input bit wr, input logic [31:0] a, input logic [1:0] acc,
                             input words_t wdata, output logic [31:0] beats[$],
                             output logic [31:0] bm, output logic [31:0] vm,
                             output logic [31:0] em);
    int n;
    n = len_of(acc);
    beats = {};
    bm = '0; vm = '0; em = '0;
    bus.en = 1'b1; bus.wren = wr; bus.addr = a; bus.acc_size = acc; bus.d_in = wdata[0];
    step();
    bus.en = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      bus.d_in = (c < n) ? wdata[c] : $urandom;
      bm[c] = bus.busy;
      vm[c] = bus.d_valid;
      em[c] = bus.err;
      if (bus.d_valid) beats.push_back(bus.d_out);
      step();
    end
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.wren = 1'b0; bus.addr = '0; bus.acc_size = '0; bus.d_in = '0;
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.d_valid !== 1'b0) begin n_bad++; $display("FAIL reset_d_valid: got %b want 0", bus.d_valid); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.d_out !== 32'h0) begin n_bad++; $display("FAIL reset_d_out: got %h want 0", bus.d_out); end
    rst = 1'b0;
    step();
    $display("reset: outputs checked after 2 reset cycles");
  endtask

  task automatic test_single();
    words_t w;
    logic [31:0] beats[$];
    logic [31:0] bm, vm, em;
    w[0] = 32'hDEAD_BEEF;
    drive_burst(1'b1, BASE, 2'b00, w, beats, bm, vm, em);
    ref_put(BASE, w[0]);
    n_cmp++; if (bm !== 32'h0) begin n_bad++; $display("FAIL single_wr_busy: got %h want 0", bm); end
    n_cmp++; if (em !== 32'h0) begin n_bad++; $display("FAIL single_wr_err: got %h want 0", em); end
    $display("write N=1 @%h data %h", BASE, w[0]);
    drive_burst(1'b0, BASE, 2'b00, w, beats, bm, vm, em);
    n_cmp++; if (vm !== 32'h2) begin n_bad++; $display("FAIL single_rd_valid: got %h want 2", vm); end
    n_cmp++;
    if (beats.size() != 1 || beats[0] !== ref_word(BASE)) begin
      n_bad++; $display("FAIL single_rd_data: got %h (n=%0d) want %h", beats[0], beats.size(), ref_word(BASE));
    end
    n_cmp++;
    if (beats.size() != 1 || beats[0][31:24] !== 8'hDE) begin
      n_bad++; $display("FAIL single_byte0: got %h want de", beats[0][31:24]);
    end
    $display("read N=1 @%h data %h", BASE, beats[0]);
  endtask

  task automatic test_burst16();
    words_t w;
    logic [31:0] beats[$];
    logic [31:0] bm, vm, em;
    logic [31:0] a;
    a = 32'h8002_0100;
    for (int i = 0; i < 16; i++) w[i] = i + 1;
    drive_burst(1'b1, a, 2'b11, w, beats, bm, vm, em);
    for (int i = 0; i < 16; i++) ref_put(a + 4 * i, w[i]);
    n_cmp++; if (bm !== busy_mask(16)) begin n_bad++; $display("FAIL b16_wr_busy: got %h want %h", bm, busy_mask(16)); end
    n_cmp++; if (vm !== 32'h0) begin n_bad++; $display("FAIL b16_wr_valid: got %h want 0", vm); end
    $display("write N=16 @%h busy mask %h", a, bm);
    drive_burst(1'b0, a, 2'b11, w, beats, bm, vm, em);
    n_cmp++; if (vm !== valid_mask(16)) begin n_bad++; $display("FAIL b16_rd_valid: got %h want %h", vm, valid_mask(16)); end
    n_cmp++; if (bm !== busy_mask(16)) begin n_bad++; $display("FAIL b16_rd_busy: got %h want %h", bm, busy_mask(16)); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (i >= beats.size() || beats[i] !== ref_word(a + 4 * i)) begin
        n_bad++; $display("FAIL b16_rd_beat%0d: got %h want %h", i, (i < beats.size()) ? beats[i] : 32'hx, ref_word(a + 4 * i));
      end
    end
    $display("read N=16 @%h beats %0d", a, beats.size());
  endtask

  task automatic test_reject();
    words_t w;
    logic [31:0] beats[$];
    logic [31:0] bm, vm, em;
    logic [31:0] top;
    top = 32'h8011_FFF0;
    for (int i = 0; i < 16; i++) w[i] = $urandom;
    drive_burst(1'b1, top, 2'b01, w, beats, bm, vm, em);
    for (int i = 0; i < 4; i++) ref_put(top + 4 * i, w[i]);
    n_cmp++; if (em !== 32'h0) begin n_bad++; $display("FAIL rej_top_fit_err: got %h want 0", em); end
    for (int i = 0; i < 16; i++) w[i] = $urandom;
    drive_burst(1'b1, 32'h8002_0002, 2'($urandom), w, beats, bm, vm, em);
    n_cmp++; if (em !== 32'h2) begin n_bad++; $display("FAIL rej_align_err: got %h want 2", em); end
    n_cmp++; if (bm !== 32'h0) begin n_bad++; $display("FAIL rej_align_busy: got %h want 0", bm); end
    $display("reject misaligned @80020002 err mask %h", em);
    drive_burst(1'b1, 32'h8011_FFFC, 2'b01, w, beats, bm, vm, em);
    n_cmp++; if (em !== 32'h2) begin n_bad++; $display("FAIL rej_range_err: got %h want 2", em); end
    n_cmp++; if (bm !== 32'h0) begin n_bad++; $display("FAIL rej_range_busy: got %h want 0", bm); end
    $display("reject overflow @8011fffc N=4 err mask %h", em);
    drive_burst(1'b0, BASE, 2'b00, w, beats, bm, vm, em);
    n_cmp++;
    if (beats.size() != 1 || beats[0] !== ref_word(BASE)) begin
      n_bad++; $display("FAIL rej_base_unchanged: got %h want %h", beats[0], ref_word(BASE));
    end
    drive_burst(1'b0, top, 2'b01, w, beats, bm, vm, em);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= beats.size() || beats[i] !== ref_word(top + 4 * i)) begin
        n_bad++; $display("FAIL rej_top_unchanged%0d: got %h want %h", i, (i < beats.size()) ? beats[i] : 32'hx, ref_word(top + 4 * i));
      end
    end
    $display("storage after rejects checked");
  endtask

  task automatic test_back_to_back();
    words_t wa, wb;
    logic [31:0] beats[$], exp_q[$], got_q[$];
    logic [31:0] bm, vm, em;
    logic [31:0] a, b, nw, last_d, hold_d;
    logic v4, v5;
    a = 32'h8002_0400;
    b = 32'h8002_0500;
    for (int i = 0; i < 16; i++) begin wa[i] = $urandom; wb[i] = $urandom; end
    drive_burst(1'b1, a, 2'b10, wa, beats, bm, vm, em);
    for (int i = 0; i < 8; i++) ref_put(a + 4 * i, wa[i]);
    drive_burst(1'b1, b, 2'b01, wb, beats, bm, vm, em);
    for (int i = 0; i < 4; i++) ref_put(b + 4 * i, wb[i]);
    for (int i = 0; i < 8; i++) exp_q.push_back(ref_word(a + 4 * i));
    for (int i = 0; i < 4; i++) exp_q.push_back(ref_word(b + 4 * i));
    vm = '0; em = '0;
    bus.en = 1'b1; bus.wren = 1'b0; bus.addr = a; bus.acc_size = 2'b10;
    step();
    for (int c = 1; c <= 14; c++) begin
      if (c < 8) begin
        bus.en = 1'b1; bus.wren = 1'($urandom); bus.addr = $urandom; bus.acc_size = 2'($urandom);
      end else if (c == 8) begin
        bus.en = 1'b1; bus.wren = 1'b0; bus.addr = b; bus.acc_size = 2'b01;
      end else begin
        bus.en = 1'b0;
      end
      vm[c] = bus.d_valid;
      em[c] = bus.err;
      if (bus.d_valid) got_q.push_back(bus.d_out);
      step();
    end
    n_cmp++; if (vm !== valid_mask(12)) begin n_bad++; $display("FAIL b2b_valid: got %h want %h", vm, valid_mask(12)); end
    n_cmp++; if (em !== 32'h0) begin n_bad++; $display("FAIL b2b_err: got %h want 0", em); end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL b2b_beat%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
      end
    end
    $display("back-to-back read 8+4 beats %0d valid mask %h", got_q.size(), vm);
    nw = $urandom;
    bus.en = 1'b1; bus.wren = 1'b0; bus.addr = b; bus.acc_size = 2'b01;
    step();
    last_d = '0; hold_d = '0; v4 = 1'b0; v5 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      if (c == 4) begin
        bus.en = 1'b1; bus.wren = 1'b1; bus.addr = a; bus.acc_size = 2'b00; bus.d_in = nw;
        last_d = bus.d_out; v4 = bus.d_valid;
      end else begin
        bus.en = 1'b0;
      end
      if (c == 5) begin hold_d = bus.d_out; v5 = bus.d_valid; end
      step();
    end
    n_cmp++; if (v4 !== 1'b1 || last_d !== ref_word(b + 12)) begin n_bad++; $display("FAIL raw_last_beat: got %h valid %b want %h", last_d, v4, ref_word(b + 12)); end
    n_cmp++; if (v5 !== 1'b0 || hold_d !== ref_word(b + 12)) begin n_bad++; $display("FAIL raw_hold: got %h valid %b want %h", hold_d, v5, ref_word(b + 12)); end
    ref_put(a, nw);
    drive_burst(1'b0, a, 2'b00, wa, beats, bm, vm, em);
    n_cmp++;
    if (beats.size() != 1 || beats[0] !== ref_word(a)) begin
      n_bad++; $display("FAIL raw_new_data: got %h want %h", beats[0], ref_word(a));
    end
    $display("write after read: last beat %h held %h new word %h", last_d, hold_d, beats[0]);
  endtask

  task automatic test_reset_mid_burst();
    words_t wp, wq;
    logic [31:0] beats[$];
    logic [31:0] bm, vm, em;
    logic [31:0] c_addr;
    c_addr = 32'h8002_0600;
    for (int i = 0; i < 16; i++) begin wp[i] = $urandom; wq[i] = $urandom; end
    drive_burst(1'b1, c_addr, 2'b10, wp, beats, bm, vm, em);
    for (int i = 0; i < 8; i++) ref_put(c_addr + 4 * i, wp[i]);
    bus.en = 1'b1; bus.wren = 1'b1; bus.addr = c_addr; bus.acc_size = 2'b10; bus.d_in = wq[0];
    step();
    bus.en = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      bus.d_in = wq[c];
      if (c == 3) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.d_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_d_valid: got %b want 0", bus.d_valid); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL midrst_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.d_out !== 32'h0) begin n_bad++; $display("FAIL midrst_d_out: got %h want 0", bus.d_out); end
    for (int i = 0; i < 4; i++) ref_put(c_addr + 4 * i, wq[i]);
    drive_burst(1'b0, c_addr, 2'b10, wp, beats, bm, vm, em);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= beats.size() || beats[i] !== ref_word(c_addr + 4 * i)) begin
        n_bad++; $display("FAIL midrst_word%0d: got %h want %h", i, (i < beats.size()) ? beats[i] : 32'hx, ref_word(c_addr + 4 * i));
      end
    end
    $display("reset in cycle 3 of 8-word write: read back %0d words", beats.size());
  endtask

  task automatic test_random();
    words_t w;
    logic [31:0] beats[$];
    logic [31:0] bm, vm, em, a, exp_vm;
    logic [1:0] acc;
    logic [31:0] d_base;
    bit wr, bad;
    int n;
    d_base = 32'h8002_1000;
    for (int blk = 0; blk < 16; blk++) begin
      for (int i = 0; i < 16; i++) w[i] = $urandom;
      drive_burst(1'b1, d_base + 64 * blk, 2'b11, w, beats, bm, vm, em);
      for (int i = 0; i < 16; i++) ref_put(d_base + 64 * blk + 4 * i, w[i]);
    end
    for (int it = 0; it < 40; it++) begin
      wr  = 1'($urandom);
      acc = 2'($urandom);
      n   = len_of(acc);
      case ($urandom_range(0, 7))
        0:       a = d_base + 32'($urandom_range(1, 3)) + 4 * $urandom_range(0, 200);
        1:       a = BASE - 4 * $urandom_range(1, 64);
        2:       a = BASE + MEM_BYTES - 4 * n + 4 * $urandom_range(1, 8);
        default: a = d_base + 4 * $urandom_range(0, 256 - n);
      endcase
      bad = ref_bad(a, acc);
      for (int i = 0; i < 16; i++) w[i] = $urandom;
      drive_burst(wr, a, acc, w, beats, bm, vm, em);
      exp_vm = (!wr && !bad) ? valid_mask(n) : 32'h0;
      n_cmp++; if (em !== (bad ? 32'h2 : 32'h0)) begin n_bad++; $display("FAIL rnd%0d_err: got %h want %h", it, em, bad ? 32'h2 : 32'h0); end
      n_cmp++; if (bm !== (bad ? 32'h0 : busy_mask(n))) begin n_bad++; $display("FAIL rnd%0d_busy: got %h want %h", it, bm, bad ? 32'h0 : busy_mask(n)); end
      n_cmp++; if (vm !== exp_vm) begin n_bad++; $display("FAIL rnd%0d_valid: got %h want %h", it, vm, exp_vm); end
      if (!bad && wr) begin
        for (int i = 0; i < n; i++) ref_put(a + 4 * i, w[i]);
      end else if (!bad) begin
        for (int i = 0; i < n; i++) begin
          n_cmp++;
          if (i >= beats.size() || beats[i] !== ref_word(a + 4 * i)) begin
            n_bad++; $display("FAIL rnd%0d_beat%0d: got %h want %h", it, i, (i < beats.size()) ? beats[i] : 32'hx, ref_word(a + 4 * i));
          end
        end
      end
      $display("rnd %0d: %s @%h N=%0d err=%0d", it, wr ? "write" : "read", a, n, bad);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_burst16();
    test_reject();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
